// File: rtl/prbs_link_test_ctrl.sv
// rtl/prbs_link_test_ctrl.sv - PRBS7 link test sequencer: settle, lock acquisition, error measurement window
module prbs_link_test_ctrl #(
    parameter int SETTLE_CYCLES = 256,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int WINDOW_WORDS  = 1048576,
    parameter int MAX_ERR       = 0,
    parameter int CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             lock_i,
    input  logic             err_i,
    output logic             tx_en_o,
    output logic             rx_en_o,
    output logic             chk_clr_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             timeout_o,
    output logic             lock_lost_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    localparam int TMR_MAX = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_SETTLE,
        S_RX_ACQ,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   word_q, word_d;
    logic               pass_q, pass_d;
    logic               timeout_q, timeout_d;
    logic               lost_q, lost_d;
    logic               tx_en_q, rx_en_q, chk_clr_q, busy_q, done_q;
    logic               clear_run;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        err_d     = err_q;
        word_d    = word_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        lost_d    = lost_q;
        clear_run = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d   = S_TX_SETTLE;
                    clear_run = 1'b1;
                end
            end
            S_TX_SETTLE: begin
                if (timer_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    state_d = S_RX_ACQ;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_RX_ACQ: begin
                // The first acquisition cycle coincides with the checker clear, so lock is not trusted yet.
                if (timer_q != '0 && lock_i) begin
                    state_d = S_MEASURE;
                end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
                timer_d = timer_q + TMR_W'(1);
            end
            S_MEASURE: begin
                word_d = word_q + CNT_W'(1);
                if (err_i && err_q != {CNT_W{1'b1}}) begin
                    err_d = err_q + CNT_W'(1);
                end
                if (!lock_i) begin
                    state_d = S_DONE;
                    lost_d  = 1'b1;
                end else if (word_d == CNT_W'(WINDOW_WORDS)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DONE && state_q != S_DONE) begin
            pass_d = !timeout_d && !lost_d && (err_d <= CNT_W'(MAX_ERR));
        end

        if (abort_i) begin
            state_d   = S_IDLE;
            clear_run = 1'b1;
        end

        if (clear_run) begin
            timer_d   = '0;
            err_d     = '0;
            word_d    = '0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
            lost_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            err_q     <= '0;
            word_q    <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            lost_q    <= 1'b0;
            tx_en_q   <= 1'b0;
            rx_en_q   <= 1'b0;
            chk_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            word_q    <= word_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            lost_q    <= lost_d;
            // Enables are decoded from the next state so they line up with state_q after the edge.
            tx_en_q   <= (state_d == S_TX_SETTLE) || (state_d == S_RX_ACQ) || (state_d == S_MEASURE);
            rx_en_q   <= (state_d == S_RX_ACQ) || (state_d == S_MEASURE);
            chk_clr_q <= (state_d == S_RX_ACQ) && (state_q != S_RX_ACQ);
            busy_q    <= (state_d == S_TX_SETTLE) || (state_d == S_RX_ACQ) || (state_d == S_MEASURE);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign tx_en_o     = tx_en_q;
    assign rx_en_o     = rx_en_q;
    assign chk_clr_o   = chk_clr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign lock_lost_o = lost_q;
    assign err_cnt_o   = err_q;
    assign word_cnt_o  = word_q;

endmodule
